// File: rtl/bsg_counter_underflow_reload_en.sv
// Programmable down-counting interval timer with reload register, periodic/one-shot
// modes, a valid/ready load port and a registered one-cycle underflow pulse.
module bsg_counter_underflow_reload_en #(
  parameter int unsigned width_p    = 24,
  parameter int unsigned init_val_p = 10000000
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               load_v_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               load_mode_i,
  output logic               load_ready_o,
  output logic [width_p-1:0] count_o,
  output logic               underflow_o,
  output logic               busy_o,
  output logic               expired_o
);

  localparam logic [width_p-1:0] InitVal = width_p'(init_val_p);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] count_q, count_d;
  logic [width_p-1:0] reload_q, reload_d;
  logic               mode_q, mode_d;
  logic               underflow_q, underflow_d;
  logic               load_fire;

  assign busy_o       = (state_q == StRun);
  assign expired_o    = (state_q == StExpired);
  assign load_ready_o = ~busy_o;
  assign load_fire    = load_v_i & load_ready_o;

  assign count_o     = count_q;
  assign underflow_o = underflow_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    mode_d      = mode_q;
    underflow_d = 1'b0;
    if (load_fire) begin
      // A load wins over start and always parks the timer in IDLE.
      reload_d = load_val_i;
      mode_d   = load_mode_i;
      count_d  = load_val_i;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) state_d = StRun;
        end
        StRun: begin
          if (stop_i) begin
            state_d = StIdle;
          end else if (en_i) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end else begin
              underflow_d = 1'b1;
              if (mode_q) count_d = reload_q;
              else        state_d = StExpired;
            end
          end
        end
        StExpired: begin
          if (start_i) begin
            count_d = reload_q;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      count_q     <= InitVal;
      reload_q    <= InitVal;
      mode_q      <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_bsg_counter_underflow_reload_en.sv
// Bench for bsg_counter_underflow_reload_en: directed plan steps followed by random
// stimulus, all checked against a behavioural timer model.
module tb_bsg_counter_underflow_reload_en;

  localparam int unsigned W    = 8;
  localparam int unsigned Init = 5;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MExp  = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en, start, stop, load_v, load_mode;
  logic [W-1:0] load_val;
  logic         load_ready, underflow, busy, expired;
  logic [W-1:0] count;

  bsg_counter_underflow_reload_en #(
    .width_p    (W),
    .init_val_p (Init)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .en_i         (en),
    .start_i      (start),
    .stop_i       (stop),
    .load_v_i     (load_v),
    .load_val_i   (load_val),
    .load_mode_i  (load_mode),
    .load_ready_o (load_ready),
    .count_o      (count),
    .underflow_o  (underflow),
    .busy_o       (busy),
    .expired_o    (expired)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model of the timer
  int m_state;
  int m_count;
  int m_reload;
  bit m_periodic;
  bit m_uf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
    check({tag, ".busy"}, 32'(busy), 32'(m_state == MRun));
    check({tag, ".expired"}, 32'(expired), 32'(m_state == MExp));
    check({tag, ".load_ready"}, 32'(load_ready), 32'(m_state != MRun));
  endtask

  task automatic model_reset();
    m_state    = MIdle;
    m_count    = Init;
    m_reload   = Init;
    m_periodic = 1'b1;
    m_uf       = 1'b0;
  endtask

  task automatic model_step();
    m_uf = 1'b0;
    if (load_v && m_state != MRun) begin
      m_reload   = int'(load_val);
      m_periodic = load_mode;
      m_count    = int'(load_val);
      m_state    = MIdle;
    end else if (m_state == MIdle) begin
      if (start) m_state = MRun;
    end else if (m_state == MRun) begin
      if (stop) m_state = MIdle;
      else if (en) begin
        if (m_count > 0) m_count = m_count - 1;
        else begin
          m_uf = 1'b1;
          if (m_periodic) m_count = m_reload;
          else            m_state = MExp;
        end
      end
    end else begin
      if (start) begin
        m_count = m_reload;
        m_state = MRun;
      end
    end
  endtask

  task automatic step(input string tag, input bit e, input bit s, input bit p, input bit lv,
                      input int v, input bit md);
    en = e; start = s; stop = p; load_v = lv; load_val = W'(v); load_mode = md;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    en = 0; start = 0; stop = 0; load_v = 0; load_val = '0; load_mode = 0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // 1: default reload of 5, periodic, free-running enable
    step("t1.start", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) step("t1.run", 1, 0, 0, 0, 0, 0);

    // 2: one-shot of 3, expire, restart
    step("t2.stop", 0, 0, 1, 0, 0, 0);
    step("t2.load", 0, 0, 0, 1, 3, 0);
    step("t2.start", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("t2.run", 1, 0, 0, 0, 0, 0);
    check("t2.expired_held", 32'(expired), 32'd1);
    step("t2.restart", 0, 1, 0, 0, 0, 0);
    check("t2.reload3", 32'(count), 32'd3);
    for (int i = 0; i < 2; i++) step("t2.run2", 1, 0, 0, 0, 0, 0);

    // 3: periodic 2, enable toggling
    step("t3.stop", 0, 0, 1, 0, 0, 0);
    step("t3.load", 0, 0, 0, 1, 2, 1);
    step("t3.start", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step("t3.run", i % 2 == 0, 0, 0, 0, 0, 0);

    // 4: stop at count 0 beats underflow; load ignored while running
    for (int i = 0; i < 8 && m_count != 0; i++) step("t4.seek", 1, 0, 0, 0, 0, 0);
    step("t4.stop_at0", 1, 0, 1, 0, 0, 0);
    check("t4.no_pulse", 32'(underflow), 32'd0);
    step("t4.start", 0, 1, 0, 0, 0, 0);
    step("t4.load_in_run", 0, 0, 0, 1, 7, 0);
    for (int i = 0; i < 4; i++) step("t4.run", 1, 0, 0, 0, 0, 0);

    // 5: load 0 together with start, then underflow every cycle
    step("t5.stop", 0, 0, 1, 0, 0, 0);
    step("t5.load_start", 0, 1, 0, 1, 0, 1);
    check("t5.idle", 32'(busy), 32'd0);
    step("t5.start", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("t5.run", 1, 0, 0, 0, 0, 0);

    // 6: asynchronous reset mid-run at count 2
    step("t6.stop", 0, 0, 1, 0, 0, 0);
    step("t6.load", 0, 0, 0, 1, 4, 1);
    step("t6.start", 0, 1, 0, 0, 0, 0);
    step("t6.run", 1, 0, 0, 0, 0, 0);
    step("t6.run", 1, 0, 0, 0, 0, 0);
    check("t6.count2", 32'(count), 32'd2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("t6.async");
    #4;
    reset_n = 1'b1;

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 6)),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bsg_counter_underflow_reload_en.md
Name: bsg_counter_underflow_reload_en

Overview:
- Programmable down-counting interval timer. It is the countdown counterpart of the overflow/set/enable up-counter.
- Software or a control FSM loads a reload value through a valid/ready handshake, starts the timer, and receives a one-cycle underflow pulse each time the count passes zero.
- Used as a periodic tick source or a one-shot timeout in control and debug paths.

Parameters:
- width_p, 24, counter and reload value width in bits.
- init_val_p, 10000000, reload and count value after reset. Must be below 2**width_p.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  decrement enable; used only in RUN.
- start_i  in  1  start or restart request.
- stop_i  in  1  halt request.
- load_v_i  in  1  reload-value valid.
- load_val_i  in  width_p  new reload value.
- load_mode_i  in  1  mode captured with the load: 1 = periodic, 0 = one-shot.
- load_ready_o  out  1  load handshake ready.
- count_o  out  width_p  current count.
- underflow_o  out  1  registered one-cycle pulse on underflow.
- busy_o  out  1  state == RUN.
- expired_o  out  1  state == EXPIRED.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i.
- Reset values while reset_n_i = 0, applied immediately:
  - state = IDLE; count_o = init_val_p; reload_r = init_val_p; mode_r = 1 (periodic).
  - underflow_o = 0; busy_o = 0; expired_o = 0; load_ready_o = 1.
- Reset mid-run aborts the run with no underflow pulse. Any pulse pending for the following cycle is dropped.
- States: IDLE, RUN, EXPIRED. There is no other state; an illegal encoding recovers to IDLE.
- load_ready_o = 1 in IDLE and EXPIRED, 0 in RUN.
- Load accepted when load_v_i & load_ready_o:
  - reload_r <= load_val_i; mode_r <= load_mode_i; count_o <= load_val_i; next state = IDLE.
  - A load accepted in the same cycle as start_i takes priority; start_i is ignored that cycle.
- IDLE:
  - start_i (with no accepted load) -> RUN. count_o is unchanged, so a run resumes from the held count.
  - stop_i and en_i are ignored.
- RUN, highest priority first:
  - stop_i -> IDLE, count_o held. stop_i beats en_i and any underflow in that cycle; no pulse is produced.
  - en_i & count_o != 0 -> count_o <= count_o - 1.
  - en_i & count_o == 0 -> underflow event. underflow_o = 1 in the following cycle only.
    - Periodic mode: count_o <= reload_r, stay in RUN.
    - One-shot mode: count_o stays 0, -> EXPIRED.
  - en_i = 0 -> hold.
  - start_i is ignored.
- Period: in RUN, one underflow occurs every reload_r + 1 enabled cycles.
  - reload_r = 0 gives an underflow on every enabled cycle.
  - Arithmetic is unsigned, width_p bits. Decrement is never applied at 0, so the count cannot wrap to all-ones.
- EXPIRED:
  - start_i -> count_o <= reload_r, -> RUN.
  - An accepted load -> IDLE with the new value.
  - stop_i and en_i are ignored.
- Timing and registers:
  - underflow_o is a flop output with no combinational path from any input.
  - busy_o and expired_o are decoded from the state register.
  - load_ready_o depends only on state.
- Consecutive underflows in periodic mode with reload_r = 0 give underflow_o held high on successive cycles, one pulse per event.

Test Plan:
1. Reset with init_val_p = 5 -> count_o = 5, load_ready_o = 1, busy_o = 0, underflow_o = 0.
   - Then start_i with en_i held at 1 -> count_o goes 4, 3, 2, 1, 0, then 5.
   - underflow_o is high for exactly one cycle, after the 0 -> 5 edge, and repeats every 6 cycles.
2. Load 3 in one-shot mode, start_i, en_i = 1 -> count_o goes 3, 2, 1, 0.
   - Underflow pulse after 4 enabled cycles, then expired_o = 1 with count_o held at 0.
   - start_i then reloads 3 and sets busy_o = 1.
3. Load 2 in periodic mode, start_i, en_i toggling 1, 0, 1, 0, ... -> count_o changes only on enabled cycles; underflow every 3 enabled cycles (every 6 clocks).
4. In RUN with count_o = 0, assert en_i and stop_i together -> state IDLE, count_o = 0, no underflow pulse.
   - During RUN, assert load_v_i = 1 with load_val_i = 7 -> load_ready_o = 0 and reload_r unchanged.
5. In IDLE, assert load_v_i (load_val_i = 0, periodic) together with start_i -> load taken and state stays IDLE.
   - Next start_i with en_i = 1 -> underflow_o high on every cycle.
6. Deassert reset_n_i asynchronously mid-RUN, between clock edges, with count_o = 2 -> count_o = init_val_p, underflow_o = 0 and state IDLE immediately, without waiting for a clock edge.
